// File: rtl/hbm_wr_engine_mo.sv
// Multi-outstanding AXI write benchmark engine for one HBM pseudo-channel.
// Issues strided bursts inside a work-group window; a run ends at the last B response.
module hbm_wr_engine_mo #(
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 6,
    parameter int NUM_IDS         = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int PARAMS_BITS     = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [PARAMS_BITS-1:0]    lt_params,
    output logic                      end_of_exec,
    output logic [63:0]               exec_cycles,
    output logic [31:0]               b_err_cnt,
    output logic                      m_axi_AWVALID,
    input  logic                      m_axi_AWREADY,
    output logic [ADDR_WIDTH-1:0]     m_axi_AWADDR,
    output logic [ID_WIDTH-1:0]       m_axi_AWID,
    output logic [7:0]                m_axi_AWLEN,
    output logic [2:0]                m_axi_AWSIZE,
    output logic [1:0]                m_axi_AWBURST,
    output logic                      m_axi_AWLOCK,
    output logic [3:0]                m_axi_AWCACHE,
    output logic [2:0]                m_axi_AWPROT,
    output logic [3:0]                m_axi_AWQOS,
    output logic [3:0]                m_axi_AWREGION,
    output logic                      m_axi_WVALID,
    input  logic                      m_axi_WREADY,
    output logic [DATA_WIDTH-1:0]     m_axi_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_axi_WSTRB,
    output logic                      m_axi_WLAST,
    output logic [ID_WIDTH-1:0]       m_axi_WID,
    input  logic                      m_axi_BVALID,
    output logic                      m_axi_BREADY,
    input  logic [1:0]                m_axi_BRESP,
    input  logic [ID_WIDTH-1:0]       m_axi_BID
);
    localparam int SIZE    = $clog2(DATA_WIDTH / 8);
    localparam int LANES32 = DATA_WIDTH / 32;
    localparam int LANES64 = DATA_WIDTH / 64;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;
    logic [PARAMS_BITS-1:0] params_q;
    logic start_q;
    logic [31:0] wg_q, wg_d, stride_q, stride_d, offset_q, offset_d, gbeat_q, gbeat_d;
    logic [31:0] b_err_q, b_err_d, beats_w;
    logic [63:0] num_ops_q, num_ops_d, aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d;
    logic [63:0] b_cnt_q, b_cnt_d, exec_q, exec_d;
    logic [7:0] awlen_q, awlen_d, beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] init_q, init_d, awaddr_q, awaddr_d;
    logic [1:0] pattern_q, pattern_d;
    logic awvalid_q, awvalid_d;
    logic [ID_WIDTH-1:0] awid_q, awid_d, wid_q, wid_d;
    logic in_setup, in_busy, idle_like;
    logic aw_hs, w_hs, w_last_hs, aw_hold, wvalid;
    logic [DATA_WIDTH-1:0] data_p1, data_p2;
    logic unused_sig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_q) state_d = S_SETUP;
            S_SETUP: state_d = (num_ops_q == 64'd0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (aw_cnt_q == num_ops_q && w_cnt_q == num_ops_q)
                    state_d = (b_cnt_q == num_ops_q) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: if (b_cnt_q == num_ops_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        end_of_exec = (state_q == S_DONE);
        in_setup    = (state_q == S_SETUP);
        in_busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    end

    assign beats_w = params_q[159:128] >> SIZE;
    assign wvalid  = (w_cnt_q < aw_cnt_q);

    always_comb begin
        wg_d = wg_q; stride_d = stride_q; num_ops_d = num_ops_q; awlen_d = awlen_q;
        init_d = init_q; pattern_d = pattern_q;
        aw_cnt_d = aw_cnt_q; w_cnt_d = w_cnt_q; b_cnt_d = b_cnt_q; offset_d = offset_q;
        gbeat_d = gbeat_q; beat_d = beat_q; exec_d = exec_q; b_err_d = b_err_q;
        awid_d = awid_q; wid_d = wid_q; awaddr_d = awaddr_q;
        aw_hs     = awvalid_q & m_axi_AWREADY;
        w_hs      = wvalid & m_axi_WREADY;
        w_last_hs = w_hs & (beat_q == awlen_q);
        if (state_q == S_IDLE && start_q) begin
            wg_d      = params_q[31:0];
            stride_d  = params_q[63:32];
            num_ops_d = params_q[127:64];
            awlen_d   = beats_w[7:0] - 8'd1;
            init_d    = params_q[ADDR_WIDTH+159:160];
            pattern_d = params_q[209:208];
        end
        if (in_setup) begin
            aw_cnt_d = '0; w_cnt_d = '0; b_cnt_d = '0; offset_d = '0;
            gbeat_d = '0; beat_d = '0; exec_d = '0; b_err_d = '0;
            awid_d = '0; wid_d = '0;
        end else begin
            if (aw_hs) begin
                aw_cnt_d = aw_cnt_q + 64'd1;
                offset_d = offset_q + stride_q;
                awid_d   = (awid_q == ID_WIDTH'(NUM_IDS - 1)) ? '0 : awid_q + 1'b1;
            end
            if (w_hs) begin
                gbeat_d = gbeat_q + 32'd1;
                beat_d  = w_last_hs ? 8'd0 : beat_q + 8'd1;
            end
            if (w_last_hs) begin
                w_cnt_d = w_cnt_q + 64'd1;
                wid_d   = (wid_q == ID_WIDTH'(NUM_IDS - 1)) ? '0 : wid_q + 1'b1;
            end
            // Stray responses outside a run are reported as errors but never move the FSM.
            if (m_axi_BVALID) begin
                if (!idle_like) b_cnt_d = b_cnt_q + 64'd1;
                if ((idle_like || m_axi_BRESP != 2'b00) && b_err_q != '1)
                    b_err_d = b_err_q + 32'd1;
            end
            if (in_busy) exec_d = exec_q + 64'd1;
        end
        // The outstanding limit only gates a fresh assertion; a pending AW is never withdrawn.
        aw_hold   = awvalid_q & ~m_axi_AWREADY;
        awvalid_d = aw_hold || (state_d == S_RUN && aw_cnt_d < num_ops_q &&
                                (aw_cnt_d - b_cnt_d) < 64'(MAX_OUTSTANDING));
        if (!aw_hold) awaddr_d = init_q + ADDR_WIDTH'(offset_d & (wg_q - 32'd1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            params_q <= '0; start_q <= 1'b0;
            wg_q <= '0; stride_q <= '0; num_ops_q <= '0; awlen_q <= '0;
            init_q <= '0; pattern_q <= '0;
            aw_cnt_q <= '0; w_cnt_q <= '0; b_cnt_q <= '0; offset_q <= '0;
            gbeat_q <= '0; beat_q <= '0; exec_q <= '0; b_err_q <= '0;
            awid_q <= '0; wid_q <= '0; awaddr_q <= '0; awvalid_q <= 1'b0;
        end else begin
            params_q <= lt_params; start_q <= start;
            wg_q <= wg_d; stride_q <= stride_d; num_ops_q <= num_ops_d; awlen_q <= awlen_d;
            init_q <= init_d; pattern_q <= pattern_d;
            aw_cnt_q <= aw_cnt_d; w_cnt_q <= w_cnt_d; b_cnt_q <= b_cnt_d; offset_q <= offset_d;
            gbeat_q <= gbeat_d; beat_q <= beat_d; exec_q <= exec_d; b_err_q <= b_err_d;
            awid_q <= awid_d; wid_q <= wid_d; awaddr_q <= awaddr_d; awvalid_q <= awvalid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES32; gi++) begin : g_p1
            assign data_p1[gi*32 +: 32] = gbeat_q;
        end
        for (gi = 0; gi < LANES64; gi++) begin : g_p2
            assign data_p2[gi*64 +: 64] = {w_cnt_q[31:0], 24'd0, beat_q};
        end
    endgenerate

    always_comb begin
        case (pattern_q)
            2'd0:    m_axi_WDATA = '0;
            2'd1:    m_axi_WDATA = data_p1;
            2'd2:    m_axi_WDATA = data_p2;
            default: m_axi_WDATA = '1;
        endcase
    end

    assign exec_cycles    = exec_q;
    assign b_err_cnt      = b_err_q;
    assign m_axi_AWVALID  = awvalid_q;
    assign m_axi_AWADDR   = awaddr_q;
    assign m_axi_AWID     = awid_q;
    assign m_axi_AWLEN    = awlen_q;
    assign m_axi_AWSIZE   = 3'(SIZE);
    assign m_axi_AWBURST  = 2'b01;
    assign m_axi_AWLOCK   = 1'b0;
    assign m_axi_AWCACHE  = 4'd0;
    assign m_axi_AWPROT   = 3'b010;
    assign m_axi_AWQOS    = 4'd0;
    assign m_axi_AWREGION = 4'd0;
    assign m_axi_WVALID   = wvalid;
    assign m_axi_WSTRB    = '1;
    assign m_axi_WLAST    = wvalid & (beat_q == awlen_q);
    assign m_axi_WID      = wid_q;
    assign m_axi_BREADY   = 1'b1;
    assign unused_sig     = ^{m_axi_BID, params_q, beats_w};
endmodule
